// File: rtl/alu_pkg.sv
// Shared ALU constants: default widths, MIPS-style op codes and sequencer state encoding.
// Combinational constants only; no latency and no flow control.
package alu_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_CODE_DEFAULT = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// UART byte stream, ALU operand/result and error signals between sequencer and its neighbours.
// master = sequencer side, slave = UART/ALU side.
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_CODE = 6
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               tx_done;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;
  logic [NB_DATA-1:0] dato1;
  logic [NB_DATA-1:0] dato2;
  logic [NB_CODE-1:0] op_code;
  logic [NB_DATA-1:0] salida;
  logic               err;

  modport master (
    input  rx_data, rx_done, tx_done, salida,
    output tx_start, tx_data, dato1, dato2, op_code, err
  );

  modport slave (
    output rx_data, rx_done, tx_done, salida,
    input  tx_start, tx_data, dato1, dato2, op_code, err
  );
endinterface

// File: rtl/alu_uart_ctrl_op_code_check.sv
// Combinational validity decode of a received op byte: upper bits zero and low bits one of
// the eight supported ALU codes. Zero latency, no flow control.
module op_code_check
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_CODE = NB_CODE_DEFAULT
) (
  input  logic [NB_DATA-1:0] op_byte,
  output logic               valid
);
  logic code_ok;

  always_comb begin
    case (op_byte[NB_CODE-1:0])
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: code_ok = 1'b1;
      default:                        code_ok = 1'b0;
    endcase
  end

  assign valid = code_ok && (op_byte[NB_DATA-1:NB_CODE] == '0);
endmodule

// File: rtl/alu_uart_ctrl.sv
// UART<->ALU sequencer: gathers dato1, dato2, op byte; tx_start 2 cycles after the op byte.
// Bytes arriving while busy are dropped; ALU_CTRL_TIMEOUT_EN adds an inter-byte timeout.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_CODE        = NB_CODE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  alu_uart_ctrl_if.master  bus
);
  logic [2:0]         state_q, state_d;
  logic [NB_DATA-1:0] dato1_q, dato1_d;
  logic [NB_DATA-1:0] dato2_q, dato2_d;
  logic [NB_CODE-1:0] op_code_q, op_code_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic               op_valid;
  logic               expired;

  op_code_check #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE)) u_op_check (
    .op_byte (bus.rx_data),
    .valid   (op_valid)
  );

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A same-cycle rx_done keeps the counter out of the expiry branch, so the byte wins.
  always_comb begin
    cnt_d   = '0;
    expired = 1'b0;
    if ((state_q == ST_WAIT_B || state_q == ST_WAIT_OP) && !bus.rx_done) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) expired = 1'b1;
      else                                    cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dato1_d   = dato1_q;
    dato2_d   = dato2_q;
    op_code_d = op_code_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (bus.rx_done) begin
          dato1_d = bus.rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (bus.rx_done) begin
          dato2_d = bus.rx_data;
          state_d = ST_WAIT_OP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (bus.rx_done) begin
          if (op_valid) begin
            op_code_d = bus.rx_data[NB_CODE-1:0];
            state_d   = ST_EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_A;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        tx_data_d = bus.salida;
        state_d   = ST_SEND;
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (bus.tx_done) state_d = ST_WAIT_A;
      default:    state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT_A;
      dato1_q   <= '0;
      dato2_q   <= '0;
      op_code_q <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dato1_q   <= dato1_d;
      dato2_q   <= dato2_d;
      op_code_q <= op_code_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  // err lands while the FSM is back in WAIT_A, so it can never overlap SEND.
  assign bus.tx_start = (state_q == ST_SEND);
  assign bus.tx_data  = tx_data_q;
  assign bus.dato1    = dato1_q;
  assign bus.dato2    = dato2_q;
  assign bus.op_code  = op_code_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed-vector bench for alu_uart_ctrl with a behavioural ALU on salida.
// Build with ALU_CTRL_TIMEOUT_EN to exercise the timeout section instead of the no-timeout one.
module tb_alu_uart_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_CODE(6)) bus ();

  alu_uart_ctrl #(.NB_DATA(8), .NB_CODE(6), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always_comb begin
    case (bus.op_code)
      OP_ADD:  bus.salida = bus.dato1 + bus.dato2;
      OP_SUB:  bus.salida = bus.dato1 - bus.dato2;
      OP_AND:  bus.salida = bus.dato1 & bus.dato2;
      OP_OR:   bus.salida = bus.dato1 | bus.dato2;
      OP_XOR:  bus.salida = bus.dato1 ^ bus.dato2;
      OP_SRA:  bus.salida = $unsigned($signed(bus.dato1) >>> bus.dato2);
      OP_SRL:  bus.salida = bus.dato1 >> bus.dato2;
      OP_NOR:  bus.salida = ~(bus.dato1 | bus.dato2);
      default: bus.salida = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic finish_tx();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  // Leaves the FSM in WAIT_TX.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk({tag, " tx_start exec"}, 32'(bus.tx_start), 32'd0);
    tick();
    chk({tag, " tx_start send"}, 32'(bus.tx_start), 32'd1);
    chk({tag, " tx_data"},       32'(bus.tx_data),  32'(exp));
    chk({tag, " err"},           32'(bus.err),      32'd0);
    chk({tag, " dato1"},         32'(bus.dato1),    32'(a));
    tick();
    chk({tag, " tx_start wait"}, 32'(bus.tx_start), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst err",      32'(bus.err),      32'd0);
    chk("rst tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst dato1",    32'(bus.dato1),    32'd0);
    chk("rst dato2",    32'(bus.dato2),    32'd0);
    chk("rst op_code",  32'(bus.op_code),  32'd0);

    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    finish_tx();
    run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    finish_tx();
    run_frame("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    finish_tx();

    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h15);
    chk("bad op err",      32'(bus.err),      32'd1);
    chk("bad op tx_start", 32'(bus.tx_start), 32'd0);
    chk("bad op op_code",  32'(bus.op_code),  32'h03);
    tick();
    chk("bad op err drop", 32'(bus.err),      32'd0);
    chk("bad op no tx",    32'(bus.tx_start), 32'd0);
    run_frame("nor", 8'h0F, 8'hF0, 8'h27, 8'h00);

    send_byte(8'hAA);
    chk("drop err",   32'(bus.err),   32'd0);
    chk("drop dato1", 32'(bus.dato1), 32'h0F);
    finish_tx();
    run_frame("and", 8'h01, 8'h01, 8'h24, 8'h01);
    finish_tx();

    send_byte(8'h77);
    chk("mid dato1", 32'(bus.dato1), 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst dato1",   32'(bus.dato1),   32'd0);
    chk("mid rst dato2",   32'(bus.dato2),   32'd0);
    chk("mid rst tx_data", 32'(bus.tx_data), 32'd0);
    run_frame("xor", 8'h0F, 8'hFF, 8'h26, 8'hF0);
    finish_tx();

`ifdef ALU_CTRL_TIMEOUT_EN
    send_byte(8'h01);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to quiet %0d", i), 32'(bus.err), 32'd0);
    end
    tick();
    chk("to err",      32'(bus.err),      32'd1);
    chk("to tx_start", 32'(bus.tx_start), 32'd0);
    tick();
    chk("to err drop", 32'(bus.err),      32'd0);
    run_frame("to after", 8'h02, 8'h03, 8'h20, 8'h05);
    finish_tx();

    send_byte(8'h01);
    repeat (15) tick();
    send_byte(8'h04);
    chk("edge err",   32'(bus.err),   32'd0);
    chk("edge dato2", 32'(bus.dato2), 32'h04);
    send_byte(8'h20);
    tick();
    chk("edge tx_start", 32'(bus.tx_start), 32'd1);
    chk("edge tx_data",  32'(bus.tx_data),  32'h05);
    tick();
    finish_tx();
`else
    send_byte(8'h01);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("idle err %0d", i), 32'(bus.err), 32'd0);
    end
    send_byte(8'h02);
    send_byte(8'h20);
    tick();
    chk("idle tx_start", 32'(bus.tx_start), 32'd1);
    chk("idle tx_data",  32'(bus.tx_data),  32'h03);
    tick();
    finish_tx();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
